i2c_burst_master: RTL and testbench

//  Parametrised successor to the single-byte I2C master in the I2C-APB bridge top.

---
 rtl/i2c_bridge_pkg.sv | 29 ++
 rtl/i2c_phase_gen.sv | 43 ++++
 rtl/i2c_burst_master.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_burst_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the I2C bridge: FSM state encoding, SCL quarter-phase
// names, ACK/NACK bus levels and the address-byte helper.
package i2c_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR     = 4'd2,
    ST_ADDR_ACK = 4'd3,
    ST_WR_BYTE  = 4'd4,
    ST_WR_ACK   = 4'd5,
    ST_RD_BYTE  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_STOP     = 4'd8
  } i2c_state_t;

  localparam logic [1:0] PH_LOW0  = 2'd0;
  localparam logic [1:0] PH_LOW1  = 2'd1;
  localparam logic [1:0] PH_HIGH0 = 2'd2;
  localparam logic [1:0] PH_HIGH1 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// SCL quarter-period timebase: one tick every CLK_DIV clocks and a 2-bit phase
// naming the quarter that the tick enters.
module i2c_phase_gen
  import i2c_bridge_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       freeze,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == CNT_LAST) && !freeze && !restart;

  // Restart parks on the last high quarter so the first tick after it is the START quarter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      phase <= PH_HIGH1;
    end else if (restart) begin
      cnt_r <= '0;
      phase <= PH_HIGH1;
    end else if (freeze) begin
      cnt_r <= cnt_r;
      phase <= phase;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      phase <= phase;
    end
  end

endmodule

// File: rtl/i2c_burst_master.sv
// I2C master running one START/address/burst/STOP transaction per request,
// with streaming tx/rx byte handshakes and sticky NACK reporting.
module i2c_burst_master
  import i2c_bridge_pkg::*;
#(
  parameter int CLK_DIV   = 125,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [6:0]       i2c_addr,
  input  logic             i2c_rw,
  input  logic [LEN_W-1:0] i2c_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             i2c_ready,
  output logic             i2c_nack,
  output logic             i2c_scl,
  inout  wire              i2c_sda
);

  i2c_state_t       state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] byte_cnt_r;
  logic [LEN_W-1:0] len_clamped;
  logic [7:0]       shreg_r;
  logic [2:0]       bit_cnt_r;
  logic             rw_r;
  logic             ack_r;
  logic             sda_low_r;
  logic             wait_tx_r;
  logic             accept;
  logic             last_byte;
  logic             sda_in;
  logic             tick;
  logic [1:0]       phase;

  assign accept      = i2c_ready && enable;
  assign len_clamped = (i2c_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : i2c_len;
  assign last_byte   = (byte_cnt_r == (len_r - LEN_W'(1)));
  assign i2c_sda     = sda_low_r ? 1'b0 : 1'bz;
  assign sda_in      = i2c_sda;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .freeze  (wait_tx_r),
    .tick    (tick),
    .phase   (phase)
  );

  // Transaction FSM; every pin and handshake output is registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      i2c_scl    <= 1'b1;
      sda_low_r  <= 1'b0;
      i2c_ready  <= 1'b1;
      i2c_nack   <= 1'b0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      len_r      <= '0;
      byte_cnt_r <= '0;
      shreg_r    <= 8'h00;
      bit_cnt_r  <= 3'd0;
      rw_r       <= 1'b0;
      ack_r      <= I2C_NACK;
      wait_tx_r  <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            len_r      <= len_clamped;
            rw_r       <= i2c_rw;
            shreg_r    <= addr_byte(i2c_addr, i2c_rw);
            i2c_nack   <= 1'b0;
            i2c_ready  <= 1'b0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            sda_low_r <= 1'b1;
            state_r   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (tick) begin
            case (phase)
              PH_LOW0:  begin i2c_scl <= 1'b0; sda_low_r <= ~shreg_r[7]; end
              PH_HIGH0: begin i2c_scl <= 1'b1; shreg_r <= {shreg_r[6:0], sda_in}; end
              PH_HIGH1: begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) state_r <= ST_ADDR_ACK;
              end
              default: ;
            endcase
          end
        end
        ST_WR_BYTE: begin
          // A byte start without data parks SCL low with the timebase frozen
          if (wait_tx_r) begin
            if (tx_valid) begin
              wait_tx_r <= 1'b0;
              tx_ready  <= 1'b1;
              shreg_r   <= tx_data;
              sda_low_r <= ~tx_data[7];
            end
          end else if (tick) begin
            case (phase)
              PH_LOW0: begin
                i2c_scl <= 1'b0;
                if (bit_cnt_r != 3'd0) begin
                  sda_low_r <= ~shreg_r[7];
                end else if (tx_valid) begin
                  tx_ready  <= 1'b1;
                  shreg_r   <= tx_data;
                  sda_low_r <= ~tx_data[7];
                end else begin
                  wait_tx_r <= 1'b1;
                end
              end
              PH_HIGH0: begin i2c_scl <= 1'b1; shreg_r <= {shreg_r[6:0], sda_in}; end
              PH_HIGH1: begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) state_r <= ST_WR_ACK;
              end
              default: ;
            endcase
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (tick) begin
            case (phase)
              PH_LOW0:  begin i2c_scl <= 1'b0; sda_low_r <= 1'b0; end
              PH_HIGH0: begin i2c_scl <= 1'b1; ack_r <= sda_in; end
              PH_HIGH1: begin
                if (ack_r == I2C_NACK) begin
                  i2c_nack <= 1'b1;
                  state_r  <= ST_STOP;
                end else if (state_r == ST_ADDR_ACK) begin
                  byte_cnt_r <= '0;
                  if (len_r == '0)  state_r <= ST_STOP;
                  else if (rw_r)    state_r <= ST_RD_BYTE;
                  else              state_r <= ST_WR_BYTE;
                end else if (last_byte) begin
                  state_r <= ST_STOP;
                end else begin
                  byte_cnt_r <= byte_cnt_r + LEN_W'(1);
                  state_r    <= ST_WR_BYTE;
                end
              end
              default: ;
            endcase
          end
        end
        ST_RD_BYTE: begin
          if (tick) begin
            case (phase)
              PH_LOW0:  begin i2c_scl <= 1'b0; sda_low_r <= 1'b0; end
              PH_HIGH0: begin i2c_scl <= 1'b1; shreg_r <= {shreg_r[6:0], sda_in}; end
              PH_HIGH1: begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                  rx_data  <= shreg_r;
                  rx_valid <= 1'b1;
                  state_r  <= ST_RD_ACK;
                end
              end
              default: ;
            endcase
          end
        end
        ST_RD_ACK: begin
          if (tick) begin
            case (phase)
              PH_LOW0:  begin i2c_scl <= 1'b0; sda_low_r <= ~(last_byte ? I2C_NACK : I2C_ACK); end
              PH_HIGH0: i2c_scl <= 1'b1;
              PH_HIGH1: begin
                if (last_byte) begin
                  state_r <= ST_STOP;
                end else begin
                  byte_cnt_r <= byte_cnt_r + LEN_W'(1);
                  state_r    <= ST_RD_BYTE;
                end
              end
              default: ;
            endcase
          end
        end
        ST_STOP: begin
          // SDA low, SCL up a quarter later, SDA up, then one idle quarter
          if (tick) begin
            case (phase)
              PH_LOW0:  begin i2c_scl <= 1'b0; sda_low_r <= 1'b1; end
              PH_LOW1:  i2c_scl <= 1'b1;
              PH_HIGH0: sda_low_r <= 1'b0;
              PH_HIGH1: begin i2c_ready <= 1'b1; state_r <= ST_IDLE; end
              default: ;
            endcase
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          i2c_scl   <= 1'b1;
          sda_low_r <= 1'b0;
          i2c_ready <= 1'b1;
          wait_tx_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Random and directed bench for i2c_burst_master: open-drain slave model at
// 7'h50/7'h51, scoreboard queues filled at issue time and drained by monitors.
module tb_i2c_burst_master;
  localparam int CLK_DIV   = 5;
  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [6:0]       i2c_addr = 7'h00;
  logic             i2c_rw = 1'b0;
  logic [LEN_W-1:0] i2c_len = '0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_valid = 1'b0;
  logic             tx_ready, rx_valid, i2c_ready, i2c_nack, i2c_scl;
  logic [7:0]       rx_data;
  wire              sda_bus;
  logic             slv_low = 1'b0;

  assign sda_bus = slv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_burst_master #(.CLK_DIV(CLK_DIV), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .enable(enable), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_len(i2c_len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .i2c_ready(i2c_ready), .i2c_nack(i2c_nack),
    .i2c_scl(i2c_scl), .i2c_sda(sda_bus)
  );

  always #10 clk = ~clk;

  logic [7:0] exp_bus[$], exp_rx[$], tx_q[$], slv_rd_q[$], dir_q[$];
  bit         exp_mack[$];
  int n_checks = 0, n_fail = 0;
  int start_cnt = 0, stop_cnt = 0, txr_cnt = 0, tx_gap = 0, gap_left = 0;
  int max_low = 0, low_len = 0, high_len = 0;
  logic scl_seen = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_present(input logic [6:0] a);
    return (a == 7'h50) || (a == 7'h51);
  endfunction

  // tx byte source with an optional gap after each consumed byte
  always @(negedge clk) begin
    if (tx_ready) begin
      txr_cnt++;
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      gap_left = tx_gap;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    tx_valid = (tx_q.size() != 0) && (gap_left == 0);
    tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  end

  // rx scoreboard
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("rx_data", rx_data, exp_rx.pop_front());
    end
  end

  // SCL pulse-width watch (no glitches, stall length capture)
  always @(negedge clk) begin
    if (rst) begin
      low_len = 0; high_len = 0; scl_seen = 1'b1;
    end else begin
      if (i2c_scl != scl_seen) begin
        if (scl_seen == 1'b0) begin
          chk("scl_low_width", int'(low_len >= CLK_DIV), 1);
          if (low_len > max_low) max_low = low_len;
        end else begin
          chk("scl_high_width", int'(high_len >= CLK_DIV), 1);
        end
        low_len = 0; high_len = 0; scl_seen = i2c_scl;
      end
      if (i2c_scl) high_len++; else low_len++;
    end
  end

  // Behavioural slave: bus events decoded from successive negedge samples
  int bit_i = 0;
  logic [7:0] sh = 8'h00, cur = 8'hFF;
  bit is_addr = 0, sel = 0, rw_s = 0, done = 0, in_frame = 0;
  logic s_scl_p = 1'b1, s_sda_p = 1'b1, sc, sd;
  always @(negedge clk) begin
    sc = i2c_scl; sd = sda_bus;
    if (rst) begin
      slv_low = 1'b0; in_frame = 0;
    end else if (s_scl_p && sc && s_sda_p && !sd) begin
      start_cnt++; in_frame = 1; is_addr = 1; bit_i = 0; sel = 0; done = 0; slv_low = 1'b0;
    end else if (s_scl_p && sc && !s_sda_p && sd) begin
      stop_cnt++; in_frame = 0; slv_low = 1'b0;
    end else if (in_frame && !s_scl_p && sc) begin
      if (bit_i < 8) begin
        sh = {sh[6:0], sd};
        if (bit_i == 7 && (is_addr || (sel && !rw_s))) begin
          if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
          else chk("bus_byte", sh, exp_bus.pop_front());
        end
        if (bit_i == 7 && is_addr) begin sel = is_present(sh[7:1]); rw_s = sh[0]; end
      end else begin
        if (!is_addr && sel && rw_s) begin
          if (exp_mack.size() == 0) chk("mack_unexpected", 1, 0);
          else chk("master_ack", sd, exp_mack.pop_front());
          if (sd) done = 1;
        end
        is_addr = 0;
      end
      bit_i = (bit_i == 8) ? 0 : bit_i + 1;
    end else if (in_frame && s_scl_p && !sc) begin
      if (bit_i == 8) begin
        slv_low = sel && (is_addr || !rw_s);
      end else if (sel && rw_s && !is_addr && !done) begin
        if (bit_i == 0) cur = (slv_rd_q.size() != 0) ? slv_rd_q.pop_front() : 8'hFF;
        slv_low = !cur[7 - bit_i];
      end else begin
        slv_low = 1'b0;
      end
    end
    s_scl_p = sc; s_sda_p = sd;
  end

  task automatic run_txn(input logic [6:0] a, input logic rw, input int len, input int gap, input bit dbl);
    int n, s0, p0, t;
    bit present;
    logic [7:0] b;
    n = (len > MAX_BURST) ? MAX_BURST : len;
    present = is_present(a);
    exp_bus.push_back({a, rw});
    for (int i = 0; i < n; i++) begin
      b = (dir_q.size() != 0) ? dir_q.pop_front() : 8'($urandom);
      if (!rw) begin
        tx_q.push_back(b);
        if (present) exp_bus.push_back(b);
      end else if (present) begin
        slv_rd_q.push_back(b); exp_rx.push_back(b); exp_mack.push_back(i == n - 1);
      end
    end
    tx_gap = gap; gap_left = 0; s0 = start_cnt; p0 = stop_cnt; txr_cnt = 0; max_low = 0;
    @(negedge clk);
    i2c_addr = a; i2c_rw = rw; i2c_len = LEN_W'(len); enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("accept_ready_low", i2c_ready, 0);
    chk("accept_nack_cleared", i2c_nack, 0);
    if (dbl) begin
      repeat (100) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
    t = 0;
    while (!i2c_ready && t < 20000) begin @(negedge clk); t++; end
    chk("done_timeout", i2c_ready, 1);
    if (dbl) repeat (60) @(negedge clk);
    chk("nack", i2c_nack, int'(!present));
    chk("tx_ready_pulses", txr_cnt, (present && !rw) ? n : 0);
    chk("start_count", start_cnt - s0, 1);
    chk("stop_count", stop_cnt - p0, 1);
    chk("bus_bytes_missing", exp_bus.size(), 0);
    chk("rx_missing", exp_rx.size(), 0);
    chk("mack_missing", exp_mack.size(), 0);
    tx_q.delete(); slv_rd_q.delete();
  endtask

  initial begin
    logic [6:0] a;
    int r;
    repeat (3) @(negedge clk);
    chk("rst_scl", i2c_scl, 1);
    chk("rst_sda", sda_bus, 1);
    chk("rst_ready", i2c_ready, 1);
    chk("rst_nack", i2c_nack, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    dir_q = {8'hA5};
    run_txn(7'h50, 1'b0, 1, 0, 0);
    dir_q = {8'h11, 8'h22, 8'h33};
    run_txn(7'h51, 1'b1, 3, 0, 0);
    run_txn(7'h7F, 1'b0, 2, 0, 0);
    run_txn(7'h50, 1'b0, 2, 400, 0);
    chk("stall_scl_held_low", int'(max_low >= 200), 1);
    run_txn(7'h50, 1'b0, 0, 0, 1);

    // Reset while the first read byte is on the bus
    exp_bus.push_back({7'h51, 1'b1});
    slv_rd_q = {8'h3C, 8'hC3, 8'h5A};
    @(negedge clk);
    i2c_addr = 7'h51; i2c_rw = 1'b1; i2c_len = LEN_W'(3); enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (250) @(negedge clk);
    chk("pre_rst_busy", i2c_ready, 0);
    chk("pre_rst_addr_seen", exp_bus.size(), 0);
    rst = 1'b1;
    #1;
    chk("midrst_scl", i2c_scl, 1);
    chk("midrst_ready", i2c_ready, 1);
    chk("midrst_rx_data", rx_data, 8'h00);
    @(negedge clk);
    #1;
    chk("midrst_sda_released", sda_bus, 1);
    repeat (3) @(negedge clk);
    exp_bus.delete(); exp_rx.delete(); exp_mack.delete(); slv_rd_q.delete(); tx_q.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_txn(7'h51, 1'b1, 2, 0, 0);

    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(0, 2);
      if (r == 0)      a = 7'h50;
      else if (r == 1) a = 7'h51;
      else             a = {1'b0, 6'($urandom)};
      run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 18), $urandom_range(0, 250), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
